quantizer_pipe: RTL and testbench

QUANTIZER_PIPE -- requirements
Module: quantizer_pipe

---
 rtl/quantizer_pkg.sv | 16 +
 rtl/quantizer_lane.sv | 56 +++++
 rtl/quantizer_pipe.sv | 125 ++++++++++++
 tb/tb_quantizer_pipe.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quantizer_pkg.sv
// Shared defaults and stage-1 record for the quantizer pipeline.
package quantizer_pkg;
    localparam int DEF_LANES = 4;
    localparam int DEF_ACC_W = 16;
    localparam int DEF_CMP_W = 4;
    localparam int DEF_SAT_W = 16;

    // Wide enough for the shifted value of accumulators up to 32 bits.
    localparam int S1_VAL_W = 33;

    typedef struct packed {
        logic [S1_VAL_W-1:0] value;
        logic                round;
        logic                relu;
    } s1_lane_t;
endpackage

// File: rtl/quantizer_lane.sv
// One quantizer lane: shift/round (feeds stage 1) and saturate/ReLU (feeds stage 2).
module quantizer_lane import quantizer_pkg::*; #(
    parameter int ACC_W   = DEF_ACC_W,
    parameter int CMP_W   = DEF_CMP_W,
    parameter int SHIFT_W = $clog2(DEF_ACC_W) + 1
) (
    input  logic [ACC_W-1:0]   acc_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic               round_i,
    output logic [ACC_W:0]     shifted_o,
    input  logic [ACC_W:0]     s1_value_i,
    input  logic               relu_i,
    output logic [CMP_W-1:0]   result_o,
    output logic               sat_o
);
    localparam int EW = ACC_W + 1;
    localparam logic signed [EW-1:0] MAX_V = EW'((64'sd1 <<< (CMP_W - 1)) - 64'sd1);
    localparam logic signed [EW-1:0] MIN_V = ~MAX_V;

    logic [SHIFT_W-1:0]   eff_shift;
    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] rnd_add;
    logic signed [EW-1:0] sum;
    logic signed [EW-1:0] v;
    logic signed [EW-1:0] clamped;

    // Shifts of ACC_W or more all give the same answer (0/-1, or 0 when
    // rounding), so clamp there to keep the rounding add inside EW bits.
    always_comb begin
        eff_shift = (int'(shift_i) > ACC_W) ? SHIFT_W'(ACC_W) : shift_i;
        ext       = {acc_i[ACC_W-1], acc_i};
        rnd_add   = '0;
        if (round_i && (eff_shift != '0)) begin
            rnd_add = EW'(1) << (eff_shift - 1'b1);
        end
        sum       = ext + rnd_add;
        shifted_o = sum >>> eff_shift;
    end

    always_comb begin
        v       = s1_value_i;
        sat_o   = 1'b0;
        clamped = v;
        if (v > MAX_V) begin
            clamped = MAX_V;
            sat_o   = 1'b1;
        end else if (v < MIN_V) begin
            clamped = MIN_V;
            sat_o   = 1'b1;
        end
        if (relu_i && clamped[EW-1]) begin
            clamped = '0;
        end
        result_o = clamped[CMP_W-1:0];
    end
endmodule

// File: rtl/quantizer_pipe.sv
// Two-stage multi-lane quantizer with valid/ready handshakes and a saturation counter.
module quantizer_pipe import quantizer_pkg::*; #(
    parameter int LANES                  = DEF_LANES,
    parameter int ACCUMULATOR_DATA_WIDTH = DEF_ACC_W,
    parameter int COMPUTE_DATA_WIDTH     = DEF_CMP_W,
    parameter int SHIFT_WIDTH            = $clog2(ACCUMULATOR_DATA_WIDTH) + 1,
    parameter int SAT_COUNT_WIDTH        = DEF_SAT_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [SHIFT_WIDTH-1:0]            cfg_shift,
    input  logic                              cfg_round_en,
    input  logic                              cfg_relu_en,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [ACCUMULATOR_DATA_WIDTH-1:0] ins [LANES],
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [COMPUTE_DATA_WIDTH-1:0]     results [LANES],
    output logic [SAT_COUNT_WIDTH-1:0]        sat_count,
    input  logic                              clear_sat
);
    localparam int ACC = ACCUMULATOR_DATA_WIDTH;
    localparam int SW1 = SAT_COUNT_WIDTH + 1;

    logic                          s1_valid_q;
    s1_lane_t                      s1_q [LANES];
    s1_lane_t                      s1_d [LANES];
    logic                          out_valid_q;
    logic [COMPUTE_DATA_WIDTH-1:0] results_q [LANES];
    logic [SAT_COUNT_WIDTH-1:0]    sat_count_q;
    logic [SAT_COUNT_WIDTH-1:0]    sat_count_d;
    logic [SW1-1:0]                sat_sum;

    logic [ACC:0]                  lane_shifted [LANES];
    logic [COMPUTE_DATA_WIDTH-1:0] lane_result  [LANES];
    logic [LANES-1:0]              lane_sat;
    logic                          s1_load;
    logic                          s2_load;
    logic                          unused_s1;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        quantizer_lane #(
            .ACC_W   (ACC),
            .CMP_W   (COMPUTE_DATA_WIDTH),
            .SHIFT_W (SHIFT_WIDTH)
        ) u_lane (
            .acc_i      (ins[g]),
            .shift_i    (cfg_shift),
            .round_i    (cfg_round_en),
            .shifted_o  (lane_shifted[g]),
            .s1_value_i (s1_q[g].value[ACC:0]),
            .relu_i     (s1_q[g].relu),
            .result_o   (lane_result[g]),
            .sat_o      (lane_sat[g])
        );
    end

    assign s2_load  = !out_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            s1_d[i].value = S1_VAL_W'($signed(lane_shifted[i]));
            s1_d[i].round = cfg_round_en;
            s1_d[i].relu  = cfg_relu_en;
        end
    end

    // Sum in one extra bit so a carry out means the counter would wrap.
    always_comb begin
        sat_sum = {1'b0, sat_count_q};
        if (s2_load && s1_valid_q) begin
            for (int i = 0; i < LANES; i++) begin
                sat_sum = sat_sum + SW1'(lane_sat[i]);
            end
        end
        if (clear_sat) begin
            sat_count_d = '0;
        end else if (sat_sum[SAT_COUNT_WIDTH]) begin
            sat_count_d = '1;
        end else begin
            sat_count_d = sat_sum[SAT_COUNT_WIDTH-1:0];
        end
    end

    // The round flag and the sign-extension bits only travel along with the vector.
    always_comb begin
        unused_s1 = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            unused_s1 = unused_s1 ^ s1_q[i].round ^ (^s1_q[i].value[S1_VAL_W-1:ACC+1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sat_count_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_q[i]      <= '0;
                results_q[i] <= '0;
            end
        end else begin
            if (s1_load) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                end
            end
            if (s2_load) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    results_q <= lane_result;
                end
            end
            sat_count_q <= sat_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign results   = results_q;
    assign sat_count = sat_count_q;
endmodule

// File: tb/tb_quantizer_pipe.sv
// Self-checking bench for quantizer_pipe: vector table, scoreboard and corner sequences.
module tb_quantizer_pipe;
    logic        clk;
    logic        rst;
    logic [4:0]  cfg_shift;
    logic        cfg_round_en;
    logic        cfg_relu_en;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ins [4];
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  results [4];
    logic [15:0] sat_count;
    logic        clear_sat;

    quantizer_pipe dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_shift    (cfg_shift),
        .cfg_round_en (cfg_round_en),
        .cfg_relu_en  (cfg_relu_en),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ins          (ins),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .results      (results),
        .sat_count    (sat_count),
        .clear_sat    (clear_sat)
    );

    typedef struct packed {
        logic [3:0][15:0] ins;
        logic [4:0]       shift;
        logic             rnd;
        logic             relu;
        logic [3:0][3:0]  exp;
        logic [2:0]       nsat;
    } vec_t;

    int              n_cmp = 0;
    int              n_err = 0;
    int              exp_sat = 0;
    int              last_wait = 0;
    logic [3:0][3:0] exp_q[$];
    vec_t            tbl [11];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0][3:0] pack_res();
        logic [3:0][3:0] r;
        for (int i = 0; i < 4; i++) r[i] = results[i];
        return r;
    endfunction

    function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3,
                                input int sh, input bit rnd, input bit relu,
                                input int e0, input int e1, input int e2, input int e3,
                                input int ns);
        vec_t t;
        t.ins[0] = 16'(a0); t.ins[1] = 16'(a1); t.ins[2] = 16'(a2); t.ins[3] = 16'(a3);
        t.shift  = 5'(sh);
        t.rnd    = rnd;
        t.relu   = relu;
        t.exp[0] = 4'(e0); t.exp[1] = 4'(e1); t.exp[2] = 4'(e2); t.exp[3] = 4'(e3);
        t.nsat   = 3'(ns);
        return t;
    endfunction

    // Reference: exact round-half-up in 64-bit, then clamp and ReLU.
    function automatic logic [3:0] model(input int x, input int sh, input bit rnd,
                                         input bit relu, output bit sat);
        longint t;
        longint v;
        t = x;
        if (rnd && sh > 0) t = t + (longint'(1) << (sh - 1));
        v = t >>> sh;
        sat = 1'b0;
        if (v > 7) begin
            v = 7; sat = 1'b1;
        end else if (v < -8) begin
            v = -8; sat = 1'b1;
        end
        if (relu && v < 0) v = 0;
        return v[3:0];
    endfunction

    task automatic send(input logic [3:0][15:0] v, input logic [4:0] sh, input bit rnd,
                        input bit relu, input logic [3:0][3:0] exp, input int ns);
        int n;
        for (int i = 0; i < 4; i++) ins[i] = v[i];
        cfg_shift    = sh;
        cfg_round_en = rnd;
        cfg_relu_en  = relu;
        in_valid     = 1'b1;
        exp_q.push_back(exp);
        exp_sat = (exp_sat + ns > 65535) ? 65535 : exp_sat + ns;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        last_wait = n;
        if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [3:0][15:0] v, input int sh, input bit rnd, input bit relu);
        logic [3:0][3:0] e;
        bit s;
        int ns;
        ns = 0;
        for (int i = 0; i < 4; i++) begin
            e[i] = model(int'($signed(v[i])), sh, rnd, relu, s);
            ns += int'(s);
        end
        send(v, 5'(sh), rnd, relu, e, ns);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_sat = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and stall-stability monitor.
    initial begin : monitor
        logic [3:0][3:0] act;
        logic [3:0][3:0] held;
        logic            stall;
        held  = '0;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                act = pack_res();
                if (stall && out_valid) chk("stall_hold", 64'(act), 64'(held));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_out: got %0h expected none", act);
                    end else begin
                        chk("result", 64'(act), 64'(exp_q.pop_front()));
                    end
                end
                stall = out_valid && !out_ready;
                held  = act;
            end
        end
    end

    initial begin : stim
        logic [3:0][15:0] v;
        logic [3:0]       bp_pat;
        int               waits;
        int               sent;
        int               pushed;
        int               cyc;
        bit               acc;

        rst = 1'b1; cfg_shift = '0; cfg_round_en = 1'b0; cfg_relu_en = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; clear_sat = 1'b0;
        for (int i = 0; i < 4; i++) ins[i] = '0;

        tbl[0]  = mk(24, 23, -24, 0,           4, 1, 0,  2,  1, -1,  0, 0);
        tbl[1]  = mk(100, -100, 7, -8,         0, 0, 0,  7, -8,  7, -8, 2);
        tbl[2]  = mk(100, -100, 7, -8,         0, 0, 1,  7,  0,  7,  0, 2);
        tbl[3]  = mk(24, 23, -24, -23,         4, 0, 0,  1,  1, -2, -2, 0);
        tbl[4]  = mk(32767, -1, -32768, 0,    16, 0, 0,  0, -1, -1,  0, 0);
        tbl[5]  = mk(32767, -1, -32768, 0,    16, 1, 0,  0,  0,  0,  0, 0);
        tbl[6]  = mk(5, -5, 32767, -32768,    20, 1, 0,  0,  0,  0,  0, 0);
        tbl[7]  = mk(5, -5, 32767, -32768,    20, 0, 0,  0, -1,  0, -1, 0);
        tbl[8]  = mk(15, -17, 16, -16,         1, 1, 0,  7, -8,  7, -8, 2);
        tbl[9]  = mk(-4, -5, -12, 4,           3, 1, 0,  0, -1, -1,  1, 0);
        tbl[10] = mk(-4, 4, 40, -40,           2, 0, 1,  0,  1,  7,  0, 2);

        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_sat_count", 64'(sat_count), 64'd0);
        chk("rst_results",   64'(pack_res()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency: accepted on edge 0, visible after edge 1.
        for (int i = 0; i < 4; i++) ins[i] = 16'(i * 2);
        cfg_shift = 5'd1; cfg_round_en = 1'b0; cfg_relu_en = 1'b0;
        in_valid = 1'b1;
        exp_q.push_back({4'd3, 4'd2, 4'd1, 4'd0});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("lat_cycle1", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_cycle2", 64'(out_valid), 64'd1);
        drain();

        // Table vectors back to back, then random ones with full throughput.
        waits = 0;
        for (int k = 0; k < 11; k++) begin
            send(tbl[k].ins, tbl[k].shift, tbl[k].rnd, tbl[k].relu, tbl[k].exp, int'(tbl[k].nsat));
            waits += last_wait;
        end
        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < 4; i++) v[i] = 16'($urandom);
            send_model(v, int'($urandom_range(0, 20)), 1'($urandom), 1'($urandom));
            waits += last_wait;
        end
        chk("throughput_waits", 64'(waits), 64'd0);
        drain();
        chk("sat_total", 64'(sat_count), 64'(exp_sat));

        // Config carried with the vector.
        send({4{16'd8}}, 5'd2, 1'b0, 1'b0, {4{4'd2}}, 0);
        send({4{16'd8}}, 5'd0, 1'b0, 1'b0, {4{4'd7}}, 4);
        drain();

        // Backpressure: out_ready follows 1,0,0,1 while six vectors stream.
        bp_pat = 4'b1001;
        sent = 0; pushed = 0; cyc = 0;
        while (sent < 6 && cyc < 200) begin
            out_ready = bp_pat[cyc % 4];
            for (int i = 0; i < 4; i++) v[i] = 16'(sent * 3 + i - 6);
            if (pushed == sent) begin
                send_model_push: begin
                    logic [3:0][3:0] e;
                    bit s;
                    for (int i = 0; i < 4; i++) e[i] = model(int'($signed(v[i])), 1, 1'b1, 1'b0, s);
                    exp_q.push_back(e);
                end
                pushed++;
            end
            for (int i = 0; i < 4; i++) ins[i] = v[i];
            cfg_shift = 5'd1; cfg_round_en = 1'b1; cfg_relu_en = 1'b0;
            in_valid = 1'b1;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        chk("bp_sent", 64'(sent), 64'd6);
        out_ready = 1'b1;
        drain();

        // Both stages full while stalled.
        out_ready = 1'b0;
        send_model({16'd1, 16'd2, 16'd3, 16'd4}, 0, 1'b0, 1'b0);
        send_model({16'd5, 16'd6, 16'd7, 16'hFFFF}, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("in_ready_full", 64'(in_ready), 64'd0);
        chk("out_valid_full", 64'(out_valid), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Reset with two vectors in flight.
        out_ready = 1'b0;
        send_model({4{16'd500}}, 0, 1'b0, 1'b0);
        send_model({4{16'd600}}, 0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_sat_count", 64'(sat_count), 64'd0);
        chk("midrst_in_ready",  64'(in_ready),  64'd1);
        exp_q.delete();
        exp_sat = 0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send_model({16'd3, 16'hFFFD, 16'd9, 16'd0}, 0, 1'b0, 1'b0);
        drain();

        // Counter edges: fill to 0xFFFE, cap at 0xFFFF, then clear beats increment.
        do_reset();
        for (int k = 0; k < 16383; k++) send({4{16'd100}}, 5'd0, 1'b0, 1'b0, {4{4'd7}}, 4);
        send({16'd0, 16'd0, 16'hFF9C, 16'd100}, 5'd0, 1'b0, 1'b0, {4'd0, 4'd0, 4'h8, 4'd7}, 2);
        drain();
        chk("sat_fffe", 64'(sat_count), 64'hFFFE);
        send({4{16'd100}}, 5'd0, 1'b0, 1'b0, {4{4'd7}}, 4);
        drain();
        chk("sat_cap", 64'(sat_count), 64'hFFFF);
        send({4{16'hFF00}}, 5'd0, 1'b0, 1'b0, {4{4'h8}}, 4);
        drain();
        chk("sat_nowrap", 64'(sat_count), 64'hFFFF);
        send({4{16'd100}}, 5'd0, 1'b0, 1'b0, {4{4'd7}}, 4);
        clear_sat = 1'b1;
        @(posedge clk);
        #1;
        clear_sat = 1'b0;
        exp_sat = 0;
        chk("clear_wins", 64'(sat_count), 64'd0);
        drain();
        chk("clear_discard", 64'(sat_count), 64'd0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
